uni_shift_reg_p: RTL and testbench

Parametrised universal shift register. It succeeds the fixed 4-bit hold/shift/load register, generalised to WIDTH bits. It adds rotate, arithmetic shift, synchronous clear, clock enable, and an autonomous burst mode that shifts out a programmed number of bits with busy/done status. It is used as the serialiser/deserialiser and general data-shuffling register in the task datapaths.

---
 rtl/uni_shift_reg_p.sv | 117 +++++++++++
 tb/tb_uni_shift_reg_p.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uni_shift_reg_p.sv
// uni_shift_reg_p: parametrised universal shift register with hold, shift,
// load, rotate, arithmetic shift, synchronous clear, clock enable and an
// autonomous burst mode that shifts a programmed number of bits out of the MSB.
//
// Ports:
//   clk        clock, rising edge
//   clr        asynchronous active-low reset
//   en         clock enable (freezes all state, including a running burst)
//   sclr       synchronous clear, active-high, wins over en
//   mode       operation select, sampled when en=1 and busy=0
//   in         parallel load data
//   sin_lsb    serial input into bit 0 on shifts toward MSB
//   sin_msb    serial input into bit WIDTH-1 on shifts toward LSB
//   burst_len  burst shift count, sampled on burst start (clamped to WIDTH)
//   q          register contents (registered)
//   sout_msb   q[WIDTH-1]
//   sout_lsb   q[0]
//   busy       burst in progress (registered)
//   done       one-cycle burst-complete pulse (registered)
module uni_shift_reg_p #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sclr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHL   = 3'b001;
  localparam logic [2:0] M_SHR   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_BURST = 3'b111;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_c;

  // Burst length clamped so a burst never shifts more than the register width
  assign len_c = (burst_len > WIDTH_C) ? WIDTH_C : burst_len;

  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];

  // Register, burst sequencing and status
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
    end else if (sclr) begin
      q     <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          case (mode)
            M_HOLD: q <= q;
            M_SHL:  q <= {q[WIDTH-2:0], sin_lsb};
            M_SHR:  q <= {sin_msb, q[WIDTH-1:1]};
            M_LOAD: q <= in;
            M_ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROTR: q <= {q[0], q[WIDTH-1:1]};
            M_ASR:  q <= {q[WIDTH-1], q[WIDTH-1:1]};
            M_BURST: begin
              cnt <= len_c;
              if (len_c == '0) begin
                done <= 1'b1;
              end else begin
                state <= BURST;
                busy  <= 1'b1;
              end
            end
            default: q <= q;
          endcase
        end
        BURST: begin
          // Mode/in/burst_len are ignored; shift out toward MSB until count hits 0
          q   <= {q[WIDTH-2:0], sin_lsb};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uni_shift_reg_p.sv
// tb_uni_shift_reg_p: directed bench for uni_shift_reg_p (WIDTH=8) with an
// arithmetic reference model checked every cycle plus literal expectations.
module tb_uni_shift_reg_p;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int M  = 1 << W;
  localparam int H  = M / 2;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic          sclr;
  logic [2:0]    mode;
  logic [W-1:0]  in;
  logic          sin_lsb;
  logic          sin_msb;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  q;
  logic          sout_msb;
  logic          sout_lsb;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Reference model state: value, remaining burst shifts, done flag
  int mq   = 0;
  int mrem = 0;
  bit mdone = 1'b0;

  uni_shift_reg_p #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .en(en), .sclr(sclr), .mode(mode), .in(in),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .burst_len(burst_len),
    .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int clamp_len(input int b);
    return (b < W) ? b : W;
  endfunction

  // Model: plain integer arithmetic on the register value
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mq <= 0; mrem <= 0; mdone <= 1'b0;
    end else if (sclr) begin
      mq <= 0; mrem <= 0; mdone <= 1'b0;
    end else if (en) begin
      mdone <= 1'b0;
      if (mrem > 0) begin
        mq   <= (mq * 2) % M + int'(sin_lsb);
        mrem <= mrem - 1;
        if (mrem == 1) mdone <= 1'b1;
      end else begin
        case (int'(mode))
          1: mq <= (mq * 2) % M + int'(sin_lsb);
          2: mq <= mq / 2 + int'(sin_msb) * H;
          3: mq <= int'(in);
          4: mq <= (mq * 2) % M + mq / H;
          5: mq <= mq / 2 + (mq % 2) * H;
          6: mq <= mq / 2 + ((mq >= H) ? H : 0);
          7: begin
            if (clamp_len(int'(burst_len)) == 0) mdone <= 1'b1;
            else mrem <= clamp_len(int'(burst_len));
          end
          default: mq <= mq;
        endcase
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started && clr) begin
      check("model_q", int'(q), mq);
      check("model_busy", int'(busy), (mrem > 0) ? 1 : 0);
      check("model_done", int'(done), int'(mdone));
      check("model_sout_msb", int'(sout_msb), mq / H);
      check("model_sout_lsb", int'(sout_lsb), mq % 2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic op(input logic [2:0] m, input logic [W-1:0] d);
    mode = m; in = d; en = 1'b1; sclr = 1'b0;
    tick();
  endtask

  task automatic lit(input string name, input int eq, input int eb, input int ed);
    check({name, "_q"}, int'(q), eq);
    check({name, "_busy"}, int'(busy), eb);
    check({name, "_done"}, int'(done), ed);
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; sclr = 1'b0; mode = 3'b000; in = '0;
    sin_lsb = 1'b0; sin_msb = 1'b0; burst_len = '0;
    repeat (2) tick();
    lit("reset", 0, 0, 0);
    clr = 1'b1;
    started = 1'b1;

    // 1: asynchronous clear mid-burst
    burst_len = 4'd3;
    op(3'b011, 8'hB4);
    op(3'b111, 8'h00);
    lit("t1_start", 'hB4, 1, 0);
    mode = 3'b000;
    @(posedge clk);
    #2 clr = 1'b0;
    #1 lit("t1_async_clr", 0, 0, 0);
    tick();
    clr = 1'b1;
    op(3'b000, 8'h00);
    lit("t1_hold_after_clr", 0, 0, 0);

    // 2: load, shifts, hold
    op(3'b011, 8'hA5);
    lit("t2_load", 'hA5, 0, 0);
    sin_lsb = 1'b1;
    op(3'b001, 8'h00);
    lit("t2_shl", 'h4B, 0, 0);
    sin_msb = 1'b0;
    op(3'b010, 8'h00);
    lit("t2_shr", 'h25, 0, 0);
    repeat (3) op(3'b000, 8'h00);
    lit("t2_hold", 'h25, 0, 0);
    sin_lsb = 1'b0;

    // 3: rotates, arithmetic shift, enable low
    op(3'b011, 8'h81); op(3'b100, 8'h00);
    lit("t3_rotl", 'h03, 0, 0);
    op(3'b011, 8'h81); op(3'b101, 8'h00);
    lit("t3_rotr", 'hC0, 0, 0);
    op(3'b011, 8'h84); op(3'b110, 8'h00);
    lit("t3_asr", 'hC2, 0, 0);
    mode = 3'b011; in = 8'hFF; en = 1'b0;
    tick();
    lit("t3_en_low", 'hC2, 0, 0);

    // 4: burst of 3, mode toggled mid-burst
    burst_len = 4'd3; sin_lsb = 1'b0;
    op(3'b011, 8'hB4);
    op(3'b111, 8'h00);
    lit("t4_start", 'hB4, 1, 0);
    check("t4_sout0", int'(sout_msb), 1);
    op(3'b011, 8'hFF);
    lit("t4_s1", 'h68, 1, 0);
    check("t4_sout1", int'(sout_msb), 0);
    op(3'b010, 8'hFF);
    lit("t4_s2", 'hD0, 1, 0);
    check("t4_sout2", int'(sout_msb), 1);
    op(3'b000, 8'h00);
    lit("t4_final", 'hA0, 0, 1);
    op(3'b000, 8'h00);
    lit("t4_done_fall", 'hA0, 0, 0);

    // 5: enable pause mid-burst, then sclr abort
    op(3'b011, 8'hB4);
    op(3'b111, 8'h00);
    op(3'b000, 8'h00);
    en = 1'b0;
    repeat (2) tick();
    lit("t5_paused", 'h68, 1, 0);
    op(3'b000, 8'h00);
    op(3'b000, 8'h00);
    lit("t5_resume_final", 'hA0, 0, 1);
    op(3'b011, 8'hB4);
    op(3'b111, 8'h00);
    op(3'b000, 8'h00);
    lit("t5_pre_sclr", 'h68, 1, 0);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    lit("t5_sclr", 0, 0, 0);
    op(3'b000, 8'h00);
    lit("t5_no_done", 0, 0, 0);

    // 6: zero-length burst and clamped over-length burst
    op(3'b011, 8'h5A);
    burst_len = 4'd0;
    op(3'b111, 8'h00);
    lit("t6_len0", 'h5A, 0, 1);
    op(3'b000, 8'h00);
    lit("t6_len0_fall", 'h5A, 0, 0);
    burst_len = 4'd12; sin_lsb = 1'b0;
    op(3'b111, 8'h00);
    lit("t6_start", 'h5A, 1, 0);
    for (int i = 0; i < 7; i++) begin
      op(3'b000, 8'h00);
      check("t6_busy_mid", int'(busy), 1);
    end
    op(3'b000, 8'h00);
    lit("t6_final", 0, 0, 1);
    en = 1'b0;
    tick();
    lit("t6_done_held", 0, 0, 1);
    op(3'b000, 8'h00);
    lit("t6_done_fall", 0, 0, 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
